// File: rtl/cdr_strobe_gen.sv
// cdr_strobe_gen: symbol-timing strobe generator with programmable period, strobe offsets and phase corrections
//   i_clk      system clock
//   i_rst      asynchronous active-low reset
//   i_en       run enable (low forces IDLE)
//   i_tick     prescaler tick qualifying each count step
//   i_nb_P     requested period in ticks, latched at start of run and on every wrap
//   i_offsets  packed per-channel strobe offsets, channel k at [k*CNT_W +: CNT_W]
//   i_adv      shorten the current period by one tick
//   i_ret      lengthen the current period by one tick
//   i_resync   restart the period at count 0
//   o_strobe   one-cycle sampling strobes, one per channel
//   o_wrap     one-cycle end-of-period pulse
//   o_cnt      current count
//   o_cfg_err  one-cycle pulse when an illegal period was replaced by MIN_P
module cdr_strobe_gen #(
  parameter int CNT_W = 6,
  parameter int N_STR = 4,
  parameter int MIN_P = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_tick,
  input  logic [CNT_W-1:0]       i_nb_P,
  input  logic [N_STR*CNT_W-1:0] i_offsets,
  input  logic                   i_adv,
  input  logic                   i_ret,
  input  logic                   i_resync,
  output logic [N_STR-1:0]       o_strobe,
  output logic                   o_wrap,
  output logic [CNT_W-1:0]       o_cnt,
  output logic                   o_cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] MIN_PV = CNT_W'(MIN_P);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, per_q, term;
  logic [CNT_W:0] term_w;
  logic adv_p, ret_p, run, step, hit, latch, per_ok;
  logic [N_STR-1:0] match;
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = i_en ? RUN : IDLE;
    run = state == RUN && i_en;
    step = run && !i_resync && i_tick;
    // adv and ret together cancel; the wider sum saturates instead of wrapping
    term_w = (adv_p && !ret_p) ? {1'b0, per_q} - (CNT_W+1)'(2) :
             (ret_p && !adv_p) ? {1'b0, per_q} : {1'b0, per_q} - (CNT_W+1)'(1);
    term = term_w[CNT_W] ? '1 : term_w[CNT_W-1:0];
    // >= keeps a late advance (arriving with cnt already at the old term) from running past the end
    hit = step && cnt >= term;
    latch = (state == IDLE && i_en) || hit;
    per_ok = i_nb_P >= MIN_PV;
    for (int k = 0; k < N_STR; k++) match[k] = cnt == i_offsets[k*CNT_W +: CNT_W];
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      cnt <= '0;
      per_q <= MIN_PV;
      adv_p <= 1'b0;
      ret_p <= 1'b0;
      o_strobe <= '0;
      o_wrap <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      o_wrap <= hit;
      o_strobe <= step ? match : '0;
      o_cfg_err <= latch && !per_ok;
      if (latch) per_q <= per_ok ? i_nb_P : MIN_PV;
      cnt <= (!run || i_resync || hit) ? '0 : cnt + CNT_W'(step);
      // a correction arriving on the wrap tick belongs to the new period
      adv_p <= run && !i_resync && (i_adv || (adv_p && !hit));
      ret_p <= run && !i_resync && (i_ret || (ret_p && !hit));
    end
  assign o_cnt = cnt;
endmodule

// File: tb/tb_cdr_strobe_gen.sv
// tb_cdr_strobe_gen: directed and randomized checks of cdr_strobe_gen against a tick-position reference model
module tb_cdr_strobe_gen;
  logic i_clk = 0, i_rst = 0, i_en = 0, i_tick = 0, i_adv = 0, i_ret = 0, i_resync = 0;
  logic [5:0] i_nb_P = 6'd25;
  logic [23:0] i_offsets;
  logic [3:0] o_strobe;
  logic o_wrap, o_cfg_err;
  logic [5:0] o_cnt;
  int offs[4] = '{1, 11, 12, 21};
  int n_chk = 0, n_fail = 0;
  // reference model: position inside the period, period length, pending corrections
  bit m_run = 0, m_adv = 0, m_ret = 0;
  int m_pos = 0, m_per = 4;
  logic [3:0] e_str = 0;
  bit e_wrap = 0, e_err = 0;

  cdr_strobe_gen dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_tick(i_tick), .i_nb_P(i_nb_P),
    .i_offsets(i_offsets), .i_adv(i_adv), .i_ret(i_ret), .i_resync(i_resync),
    .o_strobe(o_strobe), .o_wrap(o_wrap), .o_cnt(o_cnt), .o_cfg_err(o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cnt", int'(o_cnt), m_pos);
    chk("strobe", int'(o_strobe), int'(e_str));
    chk("wrap", int'(o_wrap), int'(e_wrap));
    chk("cfg_err", int'(o_cfg_err), int'(e_err));
  endtask

  task automatic take_period();
    if (int'(i_nb_P) >= 4) m_per = int'(i_nb_P);
    else begin
      m_per = 4;
      e_err = 1;
    end
  endtask

  task automatic step(input bit en, input bit tick, input bit adv, input bit ret, input bit rs);
    int len;
    i_en = en; i_tick = tick; i_adv = adv; i_ret = ret; i_resync = rs;
    i_offsets = {6'(offs[3]), 6'(offs[2]), 6'(offs[1]), 6'(offs[0])};
    @(posedge i_clk);
    e_str = 0; e_wrap = 0; e_err = 0;
    if (!m_run) begin
      m_pos = 0;
      if (en) begin
        m_run = 1;
        take_period();
      end
    end else if (!en) begin
      m_run = 0; m_pos = 0; m_adv = 0; m_ret = 0;
    end else if (rs) begin
      m_pos = 0; m_adv = 0; m_ret = 0;
    end else begin
      len = m_per + ((m_ret && !m_adv) ? 1 : 0) - ((m_adv && !m_ret) ? 1 : 0);
      if (len > 64) len = 64;
      if (tick) begin
        for (int k = 0; k < 4; k++) e_str[k] = (m_pos == offs[k]);
        if (m_pos + 1 >= len) begin
          e_wrap = 1; m_pos = 0; m_adv = adv; m_ret = ret;
          take_period();
        end else m_pos++;
      end
      if (!e_wrap) begin
        m_adv |= adv;
        m_ret |= ret;
      end
    end
    #1 check_all();
  endtask

  initial begin
    #12 check_all();
    i_rst = 1;
    step(0, 1, 0, 0, 1);
    // period 25, tick every 4 clocks, one correction each kind, then both together
    for (int i = 0; i < 900; i++)
      step(1, i % 4 == 0, i == 150 || i == 480, i == 320 || i == 480, 0);
    // period change mid-period, then an illegal period
    for (int i = 0; i < 300; i++) begin
      if (i == 40) i_nb_P = 6'd30;
      if (i == 200) i_nb_P = 6'd2;
      step(1, i % 2 == 0, 0, 0, 0);
    end
    // out-of-range offset stays silent even when lengthened; offset at the lengthened end fires
    i_nb_P = 6'd25;
    offs = '{27, 25, 0, 24};
    for (int i = 0; i < 200; i++) step(1, 1, 0, i % 26 == 3, 0);
    // resync coincident with a tick
    for (int i = 0; i < 60; i++) step(1, 1, 0, 0, i == 17 || i == 45);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    // asynchronous reset between edges
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0, 0);
    #2 i_rst = 0;
    #1;
    chk("rst_cnt", int'(o_cnt), 0);
    chk("rst_strobe", int'(o_strobe), 0);
    chk("rst_wrap", int'(o_wrap), 0);
    chk("rst_cfg", int'(o_cfg_err), 0);
    m_run = 0; m_pos = 0; m_adv = 0; m_ret = 0; m_per = 4; e_str = 0; e_wrap = 0; e_err = 0;
    #3 i_rst = 1;
    // randomized run
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0)
        i_nb_P = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(4, 40));
      if ($urandom_range(0, 99) == 0)
        for (int k = 0; k < 4; k++) offs[k] = $urandom_range(0, 45);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
